// File: rtl/ysyx_22050039_mdu.sv
// Iterative RV64M multiply/divide unit: one bit per cycle, shift-add multiply and
// restoring divide, with valid/ready handshakes and a synchronous flush.
module ysyx_22050039_mdu #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [XLEN-1:0]  in_src1,
   input  logic [XLEN-1:0]  in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   localparam int unsigned CW = $clog2(XLEN);
   localparam logic [CW-1:0] CntFull = CW'(XLEN - 1);
   localparam logic [CW-1:0] CntWord = CW'(31);
   localparam logic [3:0] OpMul  = 4'd0;
   localparam logic [3:0] OpMulw = 4'd8;

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   function automatic logic f_is_w(input logic [3:0] op);
      return op >= 4'd8 && op <= 4'd12;
   endfunction

   function automatic logic f_is_div(input logic [3:0] op);
      return (op >= 4'd4 && op <= 4'd7) || (op >= 4'd9 && op <= 4'd12);
   endfunction

   function automatic logic f_is_rem(input logic [3:0] op);
      return op == 4'd6 || op == 4'd7 || op == 4'd11 || op == 4'd12;
   endfunction

   function automatic logic f_signed1(input logic [3:0] op);
      return op == 4'd1 || op == 4'd2 || op == 4'd4 || op == 4'd6 || op == 4'd9 || op == 4'd11;
   endfunction

   function automatic logic f_signed2(input logic [3:0] op);
      return op == 4'd1 || op == 4'd4 || op == 4'd6 || op == 4'd9 || op == 4'd11;
   endfunction

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [3:0]        op_q, op_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              neg_q, neg_d, neg_rem_q, neg_rem_d, ill_q, ill_d;
   // a: multiplicand/divisor, b: multiplier/dividend-then-quotient, acc: high product/remainder
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;

   logic              in_w, in_div, in_ill, neg1, neg2, div_zero, div_ovf;
   logic [XLEN-1:0]   mask, x1, x2, mag1, mag2, min_neg, src1_ext, fast_res;

   always_comb begin
      in_w     = f_is_w(in_op);
      in_div   = f_is_div(in_op);
      in_ill   = in_op >= 4'd13;
      mask     = in_w ? XLEN'(32'hFFFF_FFFF) : '1;
      min_neg  = in_w ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
      x1       = in_src1 & mask;
      x2       = in_src2 & mask;
      neg1     = f_signed1(in_op) && (in_w ? in_src1[31] : in_src1[XLEN-1]);
      neg2     = f_signed2(in_op) && (in_w ? in_src2[31] : in_src2[XLEN-1]);
      mag1     = neg1 ? (-x1 & mask) : x1;
      mag2     = neg2 ? (-x2 & mask) : x2;
      div_zero = in_div && (x2 == '0);
      div_ovf  = in_div && f_signed2(in_op) && (x1 == min_neg) && (x2 == mask);
      src1_ext = in_w ? sext32(in_src1[31:0]) : in_src1;
      if (in_ill)        fast_res = '0;
      else if (div_zero) fast_res = f_is_rem(in_op) ? src1_ext : '1;
      else               fast_res = f_is_rem(in_op) ? '0 : src1_ext;
   end

   logic [XLEN:0]     mul_sum, rs;
   logic              rs_ge;
   logic [XLEN-1:0]   rs_diff;

   always_comb begin
      mul_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : '0);
      rs      = {acc_q, b_q[XLEN-1]};
      rs_ge   = rs >= {1'b0, a_q};
      rs_diff = rs[XLEN-1:0] - a_q;
   end

   logic [2*XLEN-1:0] prod, prod_fix;
   logic [31:0]       prod_w;
   logic [XLEN-1:0]   quo, rem, div_res, fix_res;

   // W multiply leaves product[31:0] in the top word of b after 32 right shifts
   always_comb begin
      prod     = {acc_q, b_q};
      prod_fix = neg_q ? -prod : prod;
      prod_w   = neg_q ? -b_q[XLEN-1 -: 32] : b_q[XLEN-1 -: 32];
      quo      = neg_q ? -b_q : b_q;
      rem      = neg_rem_q ? -acc_q : acc_q;
      div_res  = f_is_rem(op_q) ? rem : quo;
      if (op_q == OpMul)          fix_res = prod_fix[XLEN-1:0];
      else if (op_q == OpMulw)    fix_res = sext32(prod_w);
      else if (!f_is_div(op_q))   fix_res = prod_fix[2*XLEN-1:XLEN];
      else if (f_is_w(op_q))      fix_res = sext32(div_res[31:0]);
      else                        fix_res = div_res;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      tag_d     = tag_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      ill_d     = ill_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      res_d     = res_q;
      case (state_q)
         StIdle: begin
            if (in_valid && !flush) begin
               op_d      = in_op;
               tag_d     = in_tag;
               ill_d     = in_ill;
               neg_d     = neg1 ^ neg2;
               neg_rem_d = neg1;
               acc_d     = '0;
               a_d       = mag2;
               // W divides start with the dividend MSB at the top of b
               b_d       = (in_div && in_w) ? (mag1 << (XLEN - 32)) : mag1;
               cnt_d     = in_w ? CntWord : CntFull;
               if (in_ill || div_zero || div_ovf) begin
                  res_d   = fast_res;
                  state_d = StDone;
               end else begin
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            if (f_is_div(op_q)) begin
               acc_d = rs_ge ? rs_diff : rs[XLEN-1:0];
               b_d   = {b_q[XLEN-2:0], rs_ge};
            end else begin
               acc_d = mul_sum[XLEN:1];
               b_d   = {mul_sum[0], b_q[XLEN-1:1]};
            end
            if (cnt_q == '0) state_d = StFix;
            else             cnt_d   = cnt_q - 1'b1;
         end
         StFix: begin
            res_d   = fix_res;
            state_d = StDone;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (flush) state_d = StIdle;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         op_q      <= '0;
         tag_q     <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         ill_q     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         tag_q     <= tag_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         ill_q     <= ill_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         res_q     <= res_d;
      end
   end

   assign in_ready    = (state_q == StIdle);
   assign out_valid   = (state_q == StDone);
   assign out_result  = res_q;
   assign out_tag     = tag_q;
   assign out_illegal = ill_q;

endmodule

// File: tb/tb_ysyx_22050039_mdu.sv
// Self-checking bench for ysyx_22050039_mdu: directed vectors checked against an
// arithmetic reference model and hand-computed literals.
module tb_ysyx_22050039_mdu;

   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [3:0]  in_op = 4'd0;
   logic [63:0] in_src1 = '0;
   logic [63:0] in_src2 = '0;
   logic [4:0]  in_tag = '0;
   logic        in_ready, out_valid, out_illegal;
   logic [63:0] out_result;
   logic [4:0]  out_tag;

   int          total = 0;
   int          passed = 0;
   logic        exp_pending = 1'b0;
   logic [63:0] exp_res = '0;
   logic [4:0]  exp_tag = '0;
   logic        exp_ill = 1'b0;

   always #5 clk = ~clk;

   ysyx_22050039_mdu #(.XLEN(64), .TAG_W(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_src1     (in_src1),
      .in_src2     (in_src2),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_tag     (out_tag),
      .out_illegal (out_illegal)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
   endtask

   function automatic logic [63:0] sx(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Reference semantics of the RV64M ops, straight from the ISA rules
   function automatic logic [63:0] model_res(input logic [3:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
      logic [127:0] p;
      logic [31:0]  a32, b32, t32;
      logic [63:0]  r;
      a32 = a[31:0];
      b32 = b[31:0];
      r   = '0;
      case (op)
         4'd0: r = a * b;
         4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
         4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
         4'd3: begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
         4'd4: begin
            if (b == 0) r = '1;
            else if (a == MIN64 && b == '1) r = a;
            else r = $signed(a) / $signed(b);
         end
         4'd5: begin if (b == 0) r = '1; else r = a / b; end
         4'd6: begin
            if (b == 0) r = a;
            else if (a == MIN64 && b == '1) r = '0;
            else r = $signed(a) % $signed(b);
         end
         4'd7: begin if (b == 0) r = a; else r = a % b; end
         4'd8: begin t32 = a32 * b32; r = sx(t32); end
         4'd9: begin
            if (b32 == 0) t32 = '1;
            else if (a32 == 32'h8000_0000 && b32 == '1) t32 = a32;
            else t32 = $signed(a32) / $signed(b32);
            r = sx(t32);
         end
         4'd10: begin if (b32 == 0) t32 = '1; else t32 = a32 / b32; r = sx(t32); end
         4'd11: begin
            if (b32 == 0) t32 = a32;
            else if (a32 == 32'h8000_0000 && b32 == '1) t32 = '0;
            else t32 = $signed(a32) % $signed(b32);
            r = sx(t32);
         end
         4'd12: begin if (b32 == 0) t32 = a32; else t32 = a32 % b32; r = sx(t32); end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Edges from (and including) the accept edge until out_valid is seen
   function automatic int model_lat(input logic [3:0] op, input logic [63:0] a,
                                    input logic [63:0] b);
      logic w, dv, sg;
      w  = op >= 4'd8 && op <= 4'd12;
      dv = (op >= 4'd4 && op <= 4'd7) || (op >= 4'd9 && op <= 4'd12);
      sg = op == 4'd4 || op == 4'd6 || op == 4'd9 || op == 4'd11;
      if (op > 4'd12) return 1;
      if (dv && (w ? b[31:0] == 0 : b == 0)) return 1;
      if (dv && sg && w && a[31:0] == 32'h8000_0000 && b[31:0] == '1) return 1;
      if (dv && sg && !w && a == MIN64 && b == '1) return 1;
      return w ? 34 : 66;
   endfunction

   // Compare process: every cycle a result is presented it must match the model
   always @(negedge clk) begin
      if (rst && out_valid) begin
         if (!exp_pending) begin
            chk("spurious_valid", 64'(out_valid), 64'd0);
         end else begin
            chk("cmp_result", out_result, exp_res);
            chk("cmp_tag", 64'(out_tag), 64'(exp_tag));
            chk("cmp_illegal", 64'(out_illegal), 64'(exp_ill));
         end
      end
   end

   task automatic run(input string name, input logic [3:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] tg, input logic [63:0] lit,
                      input int hold);
      int lat;
      chk({name, "_model"}, model_res(op, a, b), lit);
      @(negedge clk);
      chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
      exp_res     = model_res(op, a, b);
      exp_tag     = tg;
      exp_ill     = (op > 4'd12);
      exp_pending = 1'b1;
      in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tg;
      @(posedge clk); #1;
      // Scramble inputs to prove the operands were captured at accept
      in_valid = 1'b0; in_op = 4'd0; in_src1 = ~a; in_src2 = ~b; in_tag = ~tg;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_latency"}, 64'(lat), 64'(model_lat(op, a, b)));
      chk({name, "_result"}, out_result, lit);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({name, "_hold_ready"}, 64'(in_ready), 64'd0);
         chk({name, "_hold_valid"}, 64'(out_valid), 64'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready   = 1'b0;
      exp_pending = 1'b0;
      chk({name, "_release"}, {62'd0, in_ready, out_valid}, 64'd2);
   endtask

   initial begin
      int nv;
      #1 rst = 1'b0;
      #10;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_result", out_result, 64'd0);
      chk("rst_tag", 64'(out_tag), 64'd0);
      chk("rst_illegal", 64'(out_illegal), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      @(negedge clk) rst = 1'b1;

      run("div",      4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFD, 0);
      run("rem",      4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run("divu_z",   4'd5, 64'h1234, 64'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run("remu_z",   4'd7, 64'h1234, 64'd0, 5'd8, 64'h1234, 0);
      run("div_ovf",  4'd4, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, MIN64, 0);
      run("rem_ovf",  4'd6, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 64'd0, 0);
      run("mulw",     4'd8, 64'h7FFF_FFFF, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      run("mulhu",    4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12,
          64'hFFFF_FFFF_FFFF_FFFE, 0);
      run("mulhsu",   4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run("divuw",    4'd10, 64'hFFFF_FFFF_8000_0000, 64'd1, 5'd14, 64'hFFFF_FFFF_8000_0000, 0);
      run("illegal",  4'd14, 64'd5, 64'd6, 5'd15, 64'd0, 0);
      run("mul",      4'd0, 64'h1234_5678, 64'd9, 5'd16, 64'hA3D7_0A38, 0);
      run("mulh",     4'd1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run("divw",     4'd9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd18, 64'hFFFF_FFFF_FFFF_FFFD, 0);
      run("remw",     4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd19, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run("remuw",    4'd12, 64'h0000_0000_FFFF_FFF9, 64'h10, 5'd20, 64'd9, 0);
      run("divw_ovf", 4'd9, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd21,
          64'hFFFF_FFFF_8000_0000, 0);
      run("hold",     4'd0, 64'd3, 64'd4, 5'd22, 64'd12, 10);

      // Flush mid-CALC together with a fast-path request that must be dropped
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd4; in_src1 = 64'd100; in_src2 = 64'd7; in_tag = 5'd3;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; in_op = 4'd5; in_src1 = 64'h55; in_src2 = 64'd0;
      in_tag = 5'd7;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_idle", {62'd0, in_ready, out_valid}, 64'd2);
      nv = 0;
      repeat (80) begin
         @(negedge clk);
         if (out_valid) nv++;
      end
      chk("flush_no_result", 64'(nv), 64'd0);

      // Asynchronous reset mid-CALC; result/tag registers hold non-zero values beforehand
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd5; in_src1 = 64'd1000; in_src2 = 64'd3; in_tag = 5'd9;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_result", out_result, 64'd0);
      chk("arst_tag", 64'(out_tag), 64'd0);
      chk("arst_illegal", 64'(out_illegal), 64'd0);
      chk("arst_ready", 64'(in_ready), 64'd1);
      @(negedge clk) rst = 1'b1;
      run("after_rst", 4'd5, 64'd1000, 64'd3, 5'd2, 64'd333, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
      $fatal(1, "timeout");
   end

endmodule
